// File: rtl/alu_seq_pkg.sv
// alu_seq shared types: opcodes, FSM states, flag bundle.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NEG = 4'd0,
    OP_INC = 4'd1,
    OP_ADC = 4'd2,
    OP_ASA = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_CAT = 4'd6,
    OP_MUL = 4'd7,
    OP_SUB = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIX
  } state_e;

  typedef struct packed {
    logic zer;
    logic neg;
    logic cout;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned WxW shift-add multiplier core.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           last
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] mc;
  logic [W-1:0]   mp;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mc  <= '0;
      mp  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      mc  <= {{W{1'b0}}, a};
      mp  <= b;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      if (mp[0]) acc <= acc + mc;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt + 1'b1;
    end
  end

  assign prod = acc;
  assign last = (cnt == CW'(W - 1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with flags, start/busy/done and iterative signed multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   opc,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         inC,
  output logic [W-1:0] outW,
  output logic         zer,
  output logic         neg,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  state_e state, nxt;
  logic load, step, wr_alu, wr_mul, last, sgn;
  logic [W-1:0] absa, absb;
  logic [2*W-1:0] prod, fixp;
  logic [W:0] hi;

  logic [W-1:0] x, y, res;
  logic [W:0] sum;
  logic ci, add, acout, aovf;

  logic [W-1:0] nres;
  flags_t nflg, flg;

  assign absa = inA[W-1] ? (~inA + 1'b1) : inA;
  assign absb = inB[W-1] ? (~inB + 1'b1) : inB;

  alu_seq_mul #(.W(W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (absa),
    .b    (absb),
    .prod (prod),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    load   = 1'b0;
    step   = 1'b0;
    wr_alu = 1'b0;
    wr_mul = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (opc == OP_MUL) begin
            load = 1'b1;
            nxt  = S_MUL;
          end else begin
            wr_alu = 1'b1;
          end
        end
      end
      S_MUL: begin
        step = 1'b1;
        if (last) nxt = S_FIX;
      end
      S_FIX: begin
        wr_mul = 1'b1;
        nxt    = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // NEG and SUB share the adder as x + ~y + 1
  always_comb begin
    x     = '0;
    y     = '0;
    ci    = 1'b0;
    add   = 1'b0;
    res   = '0;
    acout = 1'b0;
    aovf  = 1'b0;
    unique case (opc)
      OP_NEG: begin y = ~inA; ci = 1'b1; add = 1'b1; end
      OP_INC: begin
        x = inA; y = {{(W-1){1'b0}}, 1'b1}; add = 1'b1;
      end
      OP_ADC: begin x = inA; y = inB; ci = inC; add = 1'b1; end
      OP_ASA: begin
        x = inA; y = $signed(inB) >>> 1; add = 1'b1;
      end
      OP_AND: res = inA & inB;
      OP_OR:  res = inA | inB;
      OP_CAT: res = {inA[W/2-1:0], inB[W/2-1:0]};
      OP_SUB: begin x = inA; y = ~inB; ci = 1'b1; add = 1'b1; end
      default: res = '0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    if (add) begin
      res   = sum[W-1:0];
      acout = sum[W];
      aovf  = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    end
  end

  assign fixp = sgn ? (~prod + 1'b1) : prod;
  assign hi   = fixp[2*W-1:W-1];

  always_comb begin
    nres      = wr_mul ? fixp[W-1:0] : res;
    nflg.zer  = (nres == '0);
    nflg.neg  = nres[W-1];
    nflg.cout = wr_mul ? 1'b0 : acout;
    nflg.ovf  = wr_mul ? ~((&hi) | ~(|hi)) : aovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outW <= '0;
      flg  <= '0;
      done <= 1'b0;
      sgn  <= 1'b0;
    end else begin
      done <= wr_alu | wr_mul;
      if (load) sgn <= inA[W-1] ^ inB[W-1];
      if (wr_alu | wr_mul) begin
        outW <= nres;
        flg  <= nflg;
      end
    end
  end

  assign zer  = flg.zer;
  assign neg  = flg.neg;
  assign cout = flg.cout;
  assign ovf  = flg.ovf;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a result scoreboard.
module tb_alu_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, start, inC;
  logic [3:0] opc;
  logic [W-1:0] inA, inB, outW;
  logic zer, neg, cout, ovf, busy, done;

  typedef struct {
    logic [W-1:0] o;
    logic [3:0]   f;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  alu_seq #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .opc   (opc),
    .inA   (inA),
    .inB   (inB),
    .inC   (inC),
    .outW  (outW),
    .zer   (zer),
    .neg   (neg),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] o, input logic [3:0] f);
    exp_t e;
    e.o = o;
    e.f = f;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_out"}, outW, e.o);
      chk({tag, "_flg"}, {zer, neg, cout, ovf}, e.f);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    start = 1'b1;
    opc   = op;
    inA   = a;
    inB   = b;
    inC   = c;
  endtask

  // flags argument ordered {zer, neg, cout, ovf}
  task automatic single(input string tag, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] eo,
                        input logic [3:0] ef);
    drive(op, a, b, c);
    push(eo, ef);
    @(negedge clk);
    start = 1'b0;
    check_out(tag);
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic inject,
                         input logic [W-1:0] eo, input logic [3:0] ef);
    int cyc;
    int bc;
    drive(4'd7, a, b, 1'b0);
    push(eo, ef);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bc = 0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      start = inject && (cyc == 1);
      if (start) begin
        opc = 4'd1;
        inA = 16'h0000;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_busycyc"}, bc, W + 1);
    chk({tag, "_lat"}, cyc, W + 2);
    chk({tag, "_busy0"}, busy, 0);
    check_out(tag);
    @(negedge clk);
    chk({tag, "_nodone2"}, done, 0);
    chk({tag, "_hold"}, outW, eo);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    start = 1'b0;
    opc = '0;
    inA = '0;
    inB = '0;
    inC = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", outW, 0);
    chk("rst_flg", {zer, neg, cout, ovf}, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);

    single("adc", 4'd2, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 4'b0101);
    single("sub", 4'd8, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b1010);
    single("neg", 4'd0, 16'h8000, 16'h0000, 1'b0, 16'h8000, 4'b0101);
    single("asa", 4'd3, 16'h0001, 16'hFFFE, 1'b0, 16'h0000, 4'b1010);
    single("cat", 4'd6, 16'h12AB, 16'h34CD, 1'b0, 16'hABCD, 4'b0100);
    single("and", 4'd4, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 4'b0100);
    single("or",  4'd5, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 4'b0000);
    single("inc", 4'd1, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 4'b0101);
    single("sub2", 4'd8, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b0100);
    single("ill", 4'd12, 16'h0005, 16'h0007, 1'b1, 16'h0000, 4'b1000);
    @(negedge clk);
    chk("idle_done", done, 0);

    run_mul("mul1", 16'hFFFD, 16'h0007, 1'b1, 16'hFFEB, 4'b0100);
    run_mul("mul2", 16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b1001);
    run_mul("mul3", 16'h8000, 16'h0001, 1'b0, 16'h8000, 4'b0100);

    drive(4'd7, 16'h1234, 16'h0055, 1'b0);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (8) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done", done | seen[0], 0);
    chk("abort_out", outW, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_flg", {zer, neg, cout, ovf}, 0);

    single("inc2", 4'd1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b1010);
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
